// File: rtl/div_restoring_core.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FLAG_EN adds the DZ output and a one-cycle divide-by-zero path.
//
// state | meaning
// IDLE  | no result yet since reset; waiting for a START rising edge
// CALC  | iterating, one quotient bit per edge
// FIN   | result held on R/REM with DONE=1; a new START edge is accepted here too
module div_restoring_core #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             START,
    input  logic [WIDTH-1:0] DV,
    input  logic [WIDTH-1:0] DR,
    output logic             DONE,
    output logic             BUSY,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] REM
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             DZ
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic             start_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_q;

    logic             start_pulse;
    logic [WIDTH+1:0] a_sh;
    logic [WIDTH+1:0] t_diff;
    logic [WIDTH:0]   a_d;
    logic [WIDTH-1:0] q_d;

    // a_sh carries the full shifted partial remainder; the sign of t_diff decides restore.
    always_comb begin
        start_pulse = START & ~start_q;
        a_sh        = {a_q, q_q[WIDTH-1]};
        t_diff      = a_sh - {2'b00, b_q};
        a_d         = a_sh[WIDTH:0];
        q_d         = {q_q[WIDTH-2:0], 1'b0};
        if (!t_diff[WIDTH+1]) begin
            a_d = t_diff[WIDTH:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
            R       <= '0;
            REM     <= '0;
`ifdef DIV_ZERO_FLAG_EN
            DZ      <= 1'b0;
`endif
        end else begin
            start_q <= START;
            case (state_q)
                IDLE, FIN: begin
                    if (start_pulse) begin
                        q_q     <= DV;
                        b_q     <= DR;
                        a_q     <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        DONE    <= 1'b0;
                        BUSY    <= 1'b1;
                        state_q <= CALC;
`ifdef DIV_ZERO_FLAG_EN
                        DZ      <= 1'b0;
`endif
                    end
                end
                CALC: begin
`ifdef DIV_ZERO_FLAG_EN
                    // q_q still holds the dividend on the first CALC edge
                    if (b_q == '0) begin
                        R       <= '1;
                        REM     <= q_q;
                        DZ      <= 1'b1;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state_q <= FIN;
                    end else
`endif
                    begin
                        a_q   <= a_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            R       <= q_d;
                            REM     <= a_d[WIDTH-1:0];
                            DONE    <= 1'b1;
                            BUSY    <= 1'b0;
                            state_q <= FIN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring_core.sv
// Scoreboard bench for div_restoring_core; directed vectors with hand-computed results.
// Builds with or without DIV_ZERO_FLAG_EN.
module tb_div_restoring_core;

    localparam int WIDTH = 16;
`ifdef DIV_ZERO_FLAG_EN
    localparam int DZLAT = 1;
`else
    localparam int DZLAT = 16;
`endif

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             START = 1'b0;
    logic [WIDTH-1:0] DV = '0;
    logic [WIDTH-1:0] DR = '0;
    logic             DONE;
    logic             BUSY;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] REM;
`ifdef DIV_ZERO_FLAG_EN
    logic             DZ;
`endif

    div_restoring_core #(.WIDTH(WIDTH), .CW(5)) dut (
        .CLK   (CLK),
        .reset (reset),
        .START (START),
        .DV    (DV),
        .DR    (DR),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .R     (R),
        .REM   (REM)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .DZ    (DZ)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] rem;
        int               cyc;
        logic             dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE rising edge must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!reset && DONE && !done_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(R), 32'(e.r));
                chk("remainder", 32'(REM), 32'(e.rem));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(BUSY), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
                chk("dz_at_done", 32'(DZ), 32'(e.dz));
`endif
            end
        end
        done_prev = DONE;
    end

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic start_div(input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] dr,
                             input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] erem,
                             input int lat);
        exp_t e;
        START = 1'b0;
        @(negedge CLK);
        DV    = dv;
        DR    = dr;
        START = 1'b1;
        e.r   = er;
        e.rem = erem;
        e.cyc = cyc + 1 + lat;
        e.dz  = (dr == '0);
        sb.push_back(e);
        @(negedge CLK);
        chk("busy_after_start", 32'(BUSY), 32'd1);
        chk("done_after_start", 32'(DONE), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("dz_after_start", 32'(DZ), 32'd0);
`endif
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic busy_seen;
        logic done_dropped;

        repeat (3) @(negedge CLK);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_r", 32'(R), 32'd0);
        chk("reset_rem", 32'(REM), 32'd0);
        reset = 1'b0;
        @(negedge CLK);

        start_div(16'd100, 16'd7, 16'd14, 16'd2, 16);
        wait_idle(40);

        start_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 16);
        wait_idle(40);
        start_div(16'd5, 16'd9, 16'd0, 16'd5, 16);
        chk("r_held_during_calc", 32'(R), 32'hFFFF);
        wait_idle(40);

        // START held high: only one result, DONE stays up, no new busy period.
        start_div(16'd200, 16'd10, 16'd20, 16'd0, 16);
        wait_idle(40);
        busy_seen    = 1'b0;
        done_dropped = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (BUSY) busy_seen = 1'b1;
            if (!DONE) done_dropped = 1'b1;
        end
        chk("held_start_no_busy", 32'(busy_seen), 32'd0);
        chk("held_start_done_kept", 32'(done_dropped), 32'd0);
        chk("held_start_r", 32'(R), 32'd20);

        // New START edge and operand change mid-calculation are ignored.
        start_div(16'd1000, 16'd3, 16'd333, 16'd1, 16);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        DV    = 16'd7;
        DR    = 16'd2;
        START = 1'b1;
        wait_idle(40);

        // Reset during a division discards it.
        start_div(16'd50000, 16'd7, 16'd7142, 16'd6, 16);
        repeat (7) @(negedge CLK);
        reset = 1'b1;
        START = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("midreset_done", 32'(DONE), 32'd0);
        chk("midreset_busy", 32'(BUSY), 32'd0);
        chk("midreset_r", 32'(R), 32'd0);
        chk("midreset_rem", 32'(REM), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge CLK);
        chk("no_done_after_reset", 32'(DONE), 32'd0);
        chk("no_busy_after_reset", 32'(BUSY), 32'd0);

        // Divide by zero, then a normal division that must clear any DZ flag.
        start_div(16'd1234, 16'd0, 16'hFFFF, 16'd1234, DZLAT);
        wait_idle(40);
        start_div(16'd100, 16'd7, 16'd14, 16'd2, 16);
        wait_idle(40);

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
